// File: rtl/keypad_calc_pkg.sv
// Shared key codes, entry-state encoding and default sizing for the keypad calculator.
// Optional backspace support is enabled by defining KEY_BACKSPACE_EN.
package keypad_calc_pkg;

    localparam int unsigned DEFAULT_MAX_DIGITS = 3;
    localparam int unsigned DEFAULT_VALUE_W    = 10;

    localparam logic [3:0] KEY_PLUS   = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;
    localparam logic [3:0] KEY_BKSP   = 4'hD;
    localparam logic [3:0] KEY_EQUALS = 4'hE;

    typedef enum logic [1:0] {
        ENTER_A     = 2'd0,
        ENTER_B     = 2'd1,
        SHOW_RESULT = 2'd2
    } entry_state_t;

endpackage

// File: rtl/digit_accumulator.sv
// Holds one decimal operand being typed in: x10+d on digit, saturating at MAX_DIGITS.
// With KEY_BACKSPACE_EN defined, backspace drops the last digit (/10).
module digit_accumulator
    import keypad_calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = DEFAULT_MAX_DIGITS,
    parameter int unsigned VALUE_W    = DEFAULT_VALUE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push_digit,
    input  logic [3:0]         digit,
    input  logic               backspace,
    output logic [VALUE_W-1:0] value,
    output logic [1:0]         count
);

    logic [VALUE_W-1:0] value_q, value_d, base_value;
    logic [1:0]         count_q, count_d, base_count;

    // clear and push together load a fresh single-digit value
    always_comb begin
        base_value = clear ? '0 : value_q;
        base_count = clear ? '0 : count_q;
        value_d    = base_value;
        count_d    = base_count;
        if (push_digit) begin
            if (base_count < 2'(MAX_DIGITS)) begin
                value_d = (base_value << 3) + (base_value << 1) + VALUE_W'(digit);
                count_d = base_count + 2'd1;
            end
`ifdef KEY_BACKSPACE_EN
        end else if (backspace) begin
            if (base_count != 2'd0) begin
                value_d = base_value / VALUE_W'(10);
                count_d = base_count - 2'd1;
            end
`endif
        end
    end

`ifndef KEY_BACKSPACE_EN
    logic unused_backspace;
    assign unused_backspace = backspace;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/keypad_calc_entry.sv
// Keypad calculator entry: builds two decimal operands from strobed keys and adds them on equals.
// Defining KEY_BACKSPACE_EN enables the backspace key (D) during operand entry.
module keypad_calc_entry
    import keypad_calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = DEFAULT_MAX_DIGITS,
    parameter int unsigned VALUE_W    = DEFAULT_VALUE_W,
    parameter int unsigned SUM_W      = VALUE_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic [VALUE_W-1:0] operand_a,
    output logic [VALUE_W-1:0] operand_b,
    output logic [SUM_W-1:0]   sum,
    output logic [SUM_W-1:0]   display_value,
    output logic [1:0]         digit_count,
    output logic [1:0]         entry_state,
    output logic               result_valid
);

    localparam logic [1:0] ST_ENTER_A     = 2'(ENTER_A);
    localparam logic [1:0] ST_ENTER_B     = 2'(ENTER_B);
    localparam logic [1:0] ST_SHOW_RESULT = 2'(SHOW_RESULT);

    logic [1:0]         state_q;
    logic [VALUE_W-1:0] a_q, b_q;
    logic [SUM_W-1:0]   sum_q;
    logic               result_valid_q;

    logic               acc_clear, acc_push, acc_bksp;
    logic [VALUE_W-1:0] acc_value;
    logic [1:0]         acc_count;
    logic               is_digit;

    assign is_digit = (key_code <= 4'd9);

    always_comb begin
        acc_clear = 1'b0;
        acc_push  = 1'b0;
        acc_bksp  = 1'b0;
        if (state_q == 2'd3) begin
            acc_clear = 1'b1;
        end else if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                acc_clear = 1'b1;
            end else if (is_digit) begin
                acc_push  = 1'b1;
                acc_clear = (state_q == ST_SHOW_RESULT);
            end else if (key_code == KEY_PLUS && state_q == ST_ENTER_A) begin
                acc_clear = 1'b1;
`ifdef KEY_BACKSPACE_EN
            end else if (key_code == KEY_BKSP && state_q != ST_SHOW_RESULT) begin
                acc_bksp = 1'b1;
`endif
            end
        end
    end

    digit_accumulator #(
        .MAX_DIGITS (MAX_DIGITS),
        .VALUE_W    (VALUE_W)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .push_digit (acc_push),
        .digit      (key_code),
        .backspace  (acc_bksp),
        .value      (acc_value),
        .count      (acc_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_ENTER_A;
            a_q            <= '0;
            b_q            <= '0;
            sum_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (state_q == 2'd3) begin
                state_q <= ST_ENTER_A;
            end else if (key_valid) begin
                if (key_code == KEY_CLEAR) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    sum_q   <= '0;
                    state_q <= ST_ENTER_A;
                end else if (is_digit && state_q == ST_SHOW_RESULT) begin
                    b_q     <= '0;
                    state_q <= ST_ENTER_A;
                end else if (key_code == KEY_PLUS && state_q == ST_ENTER_A) begin
                    a_q     <= acc_value;
                    state_q <= ST_ENTER_B;
                end else if (key_code == KEY_EQUALS && state_q == ST_ENTER_B) begin
                    b_q            <= acc_value;
                    sum_q          <= SUM_W'(a_q) + SUM_W'(acc_value);
                    result_valid_q <= 1'b1;
                    state_q        <= ST_SHOW_RESULT;
                end
            end
        end
    end

    // The live entry comes straight from the accumulator; frozen operands from a_q/b_q
    always_comb begin
        operand_a     = (state_q == ST_ENTER_A) ? acc_value : a_q;
        operand_b     = (state_q == ST_ENTER_B) ? acc_value : b_q;
        display_value = '0;
        unique case (state_q)
            ST_ENTER_A:     display_value = SUM_W'(operand_a);
            ST_ENTER_B:     display_value = SUM_W'(operand_b);
            ST_SHOW_RESULT: display_value = sum_q;
            default:        display_value = '0;
        endcase
    end

    assign sum          = sum_q;
    assign digit_count  = acc_count;
    assign entry_state  = state_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_keypad_calc_entry.sv
// Directed bench for keypad_calc_entry; honours KEY_BACKSPACE_EN when defined.
module tb_keypad_calc_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [9:0]  operand_a, operand_b;
    logic [10:0] sum, display_value;
    logic [1:0]  digit_count, entry_state;
    logic        result_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_calc_entry dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .sum           (sum),
        .display_value (display_value),
        .digit_count   (digit_count),
        .entry_state   (entry_state),
        .result_valid  (result_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge; returns on the next falling edge with the key applied.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int a, input int b, input int s,
                             input int disp, input int cnt, input int st, input int rv);
        check({tag, ".operand_a"}, 32'(operand_a), a);
        check({tag, ".operand_b"}, 32'(operand_b), b);
        check({tag, ".sum"}, 32'(sum), s);
        check({tag, ".display"}, 32'(display_value), disp);
        check({tag, ".count"}, 32'(digit_count), cnt);
        check({tag, ".state"}, 32'(entry_state), st);
        check({tag, ".result_valid"}, 32'(result_valid), rv);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;

        // 1: reset wins over a strobed digit
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        key_valid = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);

        // key_code ignored without strobe
        key_code = 4'd3;
        idle();
        check("no_strobe.count", 32'(digit_count), 0);

        // 2: 123 + 45
        press(4'd1); press(4'd2); press(4'd3);
        check_all("enter_a", 123, 0, 0, 123, 3, 0, 0);
        press(4'hB); press(4'hF);
        check("ignored_bf.a", 32'(operand_a), 123);
        press(4'hA);
        check_all("plus", 123, 0, 0, 0, 0, 1, 0);
        press(4'd4);
        press(4'hA);
        check("plus_in_b.state", 32'(entry_state), 1);
        press(4'd5);
        check_all("enter_b", 123, 45, 0, 45, 2, 1, 0);
        press(4'hE);
        check_all("equals", 123, 45, 168, 168, 2, 2, 1);
        idle();
        check("equals.pulse_end", 32'(result_valid), 0);
        press(4'hE);
        check("equals_in_show.rv", 32'(result_valid), 0);

        // 6a: digit after result starts new calculation, sum held
        press(4'd7);
        check_all("new_calc", 7, 0, 168, 7, 1, 0, 0);

        // 3: saturation and maximum sum
        press(4'hC);
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        check("sat.a", 32'(operand_a), 999);
        check("sat.count", 32'(digit_count), 3);
        press(4'hA); press(4'd9); press(4'd9); press(4'd9); press(4'hE);
        check_all("max_sum", 999, 999, 1998, 1998, 3, 2, 1);

        // 4: clear then ignored equals
        press(4'd7); press(4'hA); press(4'd3); press(4'hC);
        check_all("clear", 0, 0, 0, 0, 0, 0, 0);
        press(4'hE);
        check_all("equals_in_a", 0, 0, 0, 0, 0, 0, 0);

        // leading zero counts as a digit
        press(4'd0);
        check("lead0.count", 32'(digit_count), 1);
        press(4'hC);

        // 5: backspace
        press(4'd1); press(4'd2); press(4'hD);
`ifdef KEY_BACKSPACE_EN
        check("bksp.a", 32'(operand_a), 1);
        check("bksp.count", 32'(digit_count), 1);
        press(4'hD); press(4'hD);
        check("bksp_empty.a", 32'(operand_a), 0);
        check("bksp_empty.count", 32'(digit_count), 0);
`else
        check("no_bksp.a", 32'(operand_a), 12);
        check("no_bksp.count", 32'(digit_count), 2);
`endif

        // 6b: reset mid-entry of operand B
        press(4'hC); press(4'd1); press(4'hA); press(4'd4);
        check("mid_b.b", 32'(operand_b), 4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
